d_instr_queue: RTL
==================

// Module: d_instr_queue
// PURPOSE
//  Decode-side receiver for the fetch interface: accepts f_pc/instr from fetch, buffers them in a small FIFO,
//  presents them to decode with a valid/ready handshake, and drives d_ready, br_en and br_addr back to fetch.
//  Resolves JAL redirects at the fetch boundary (no wrong-path fetch).
//  Applies execute-stage redirects with a full queue flush.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >= 2
//  PTR_W   $clog2(DEPTH)   pointer width (derived, do not override)
// PORTS
//  clock        in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low; all state cleared while low
//  f_pc         in   32  PC of instruction presented by fetch (valid every cycle out of reset)
//  instr        in   32  instruction at f_pc
//  d_ready      out  1   fetch advances PC at next edge when 1
//  br_en        out  1   with d_ready: fetch loads br_addr instead of PC+4
//  br_addr      out  32  redirect target
//  ex_br_en     in   1   execute redirect/mispredict (1-cycle pulse)
//  ex_br_addr   in   32  execute redirect target
//  dec_ready    in   1   decode consumes head entry when d_valid & dec_ready
//  d_valid      out  1   head entry valid
//  d_pc         out  32  head entry PC
//  d_instr      out  32  head entry instruction
//  d_pred_taken out  1   head entry was predicted taken (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0): count=0, rd/wr ptr=0, d_valid=0, d_pc=0, d_instr=0, d_pred_taken=0; async assert, sync release.
//  pop  = d_valid & dec_ready & !ex_br_en.
//  push = (count<DEPTH) & !ex_br_en & reset; d_ready = (count<DEPTH) | ex_br_en.
//  d_ready depends on registered count only, never on dec_ready. Full queue: no push even if a pop happens that cycle.
//  Push stores {f_pc, instr, pred} at wr_ptr. Latency: pushed at edge N -> visible on d_* after edge N if queue empty.
//  d_pc/d_instr/d_pred_taken are the head entry; don't-care when d_valid=0.
//  Push and pop in the same cycle: count unchanged; both pointers advance, wrapping modulo DEPTH.
//  JAL (instr[6:0]=7'b1101111) on a push: br_en=1, br_addr = f_pc + sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
//  The JAL itself is pushed (decode needs rd <- pc+4), with pred=1.
//  JALR is not redirected here; execute resolves it via ex_br_en.
//  ex_br_en=1: combinational br_en=1, br_addr=ex_br_addr, d_ready=1 (fetch takes target at next edge).
//  At the edge: count<=0, ptrs<=0; incoming instr dropped; no pop. ex_br_en overrides a JAL redirect in the same cycle.
//  Otherwise br_en=0, br_addr=0.
//  Arithmetic: 32-bit adds, wrap modulo 2^32, no overflow flag.
//  reset asserted mid-operation: queue emptied immediately; outputs at reset values asynchronously.
// CONFIGURATION
//  STATIC_BTFN_PREDICT_EN defined: B-type (instr[6:0]=7'b1100011) with instr[31]=1 (backward) on a push behaves like JAL:
//    br_en=1, br_addr = f_pc + sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); stored pred=1.
//    Forward branches: pred=0, no redirect.
//  STATIC_BTFN_PREDICT_EN undefined: branches never redirect; pred=1 only for JAL; d_pred_taken otherwise 0.
//  Port list is identical in both builds.
// TESTING
//  1 Reset low 3 cycles, release; f_pc=0,4,8 with ADDI, dec_ready=1 -> d_ready=1.
//    d_valid from cycle after first push; d_pc=0,4,8 in order; br_en=0 throughout.
//  2 dec_ready=0, 5 sequential instrs at 0..16 -> 4 pushed (pc 0..12); d_ready=0 while count=4, pc 16 held by fetch.
//    dec_ready=1 -> drains 0,4,8,12, then 16 accepted.
//  3 instr=32'h0100006F (JAL x0,+16) at f_pc=32'h100 -> same cycle br_en=1, br_addr=32'h110.
//    Queue receives 0x100 (d_pred_taken=1), then 0x110; 0x104 never enters.
//  4 Queue holds 3 entries, ex_br_en=1 with ex_br_addr=32'h200 and a JAL at fetch -> br_addr=32'h200.
//    Next cycle count=0, d_valid=0; the JAL is not queued.
//  5 Full queue, dec_ready=1 with one push attempt -> d_ready=0, count drops to 3, no push that cycle.
//    Also: pointer wrap after 9 push/pop pairs keeps FIFO order.
//  6 instr=32'hFE000EE3 (BEQ x0,x0,-4) at f_pc=32'h40 -> with STATIC_BTFN_PREDICT_EN: br_en=1, br_addr=32'h3C, pred=1.
//    Without STATIC_BTFN_PREDICT_EN: br_en=0, pred=0, next f_pc=32'h44 queued.

Source files
------------

// File: rtl/d_instr_queue_if.sv
// Fetch/decode/execute handshake bundle around the decode-side instruction queue.
// slave  : the queue itself.
// master : the environment (fetch, decode and execute) driving the queue.
interface d_instr_queue_if;
  // Fetch side
  logic [31:0] f_pc;
  logic [31:0] instr;
  logic        d_ready;
  logic        br_en;
  logic [31:0] br_addr;
  // Execute redirect
  logic        ex_br_en;
  logic [31:0] ex_br_addr;
  // Decode side
  logic        dec_ready;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_pred_taken;

  modport slave (
    input  f_pc, instr, ex_br_en, ex_br_addr, dec_ready,
    output d_ready, br_en, br_addr, d_valid, d_pc, d_instr, d_pred_taken
  );

  modport master (
    output f_pc, instr, ex_br_en, ex_br_addr, dec_ready,
    input  d_ready, br_en, br_addr, d_valid, d_pc, d_instr, d_pred_taken
  );
endinterface

// File: rtl/d_instr_queue.sv
// Decode-side instruction queue: buffers {pc, instr, pred} from fetch in a
// DEPTH-entry FIFO, resolves JAL redirects as the JAL is accepted, and flushes
// completely on an execute redirect.
// Optional feature macro: STATIC_BTFN_PREDICT_EN (backward branches predicted
// taken and redirected like JAL). Port list is the same in both builds.
module d_instr_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  d_instr_queue_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        full_c;
  logic        push_c;
  logic        pop_c;
  logic        is_jal_c;
  logic        redirect_c;
  logic [31:0] jal_tgt_c;
  logic [31:0] tgt_c;
  entry_t      wr_entry_c;

  assign full_c    = (count == CNT_W'(DEPTH));
  assign is_jal_c  = (bus.instr[6:0] == OP_JAL);
  assign jal_tgt_c = bus.f_pc + {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                                 bus.instr[20], bus.instr[30:21], 1'b0};

`ifdef STATIC_BTFN_PREDICT_EN
  logic        is_bwd_br_c;
  logic [31:0] br_tgt_c;

  // Backward conditional branches are statically predicted taken.
  assign is_bwd_br_c = (bus.instr[6:0] == OP_BRANCH) && bus.instr[31];
  assign br_tgt_c    = bus.f_pc + {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                                   bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign redirect_c  = is_jal_c | is_bwd_br_c;
  assign tgt_c       = is_jal_c ? jal_tgt_c : br_tgt_c;
`else
  // Only JAL redirects; branches flow through untouched.
  assign redirect_c  = is_jal_c;
  assign tgt_c       = jal_tgt_c;
`endif

  // Handshake qualifiers; an execute redirect blocks both push and pop.
  assign push_c = !full_c && !bus.ex_br_en && reset;
  assign pop_c  = bus.d_valid && bus.dec_ready && !bus.ex_br_en;

  // Entry captured from fetch on a push.
  always_comb begin
    wr_entry_c       = '0;
    wr_entry_c.pc    = bus.f_pc;
    wr_entry_c.instr = bus.instr;
    wr_entry_c.pred  = redirect_c;
  end

  // Fetch-side response: execute redirect wins over a predicted redirect.
  always_comb begin
    bus.d_ready = !full_c || bus.ex_br_en;
    bus.br_en   = 1'b0;
    bus.br_addr = '0;
    if (bus.ex_br_en) begin
      bus.br_en   = 1'b1;
      bus.br_addr = bus.ex_br_addr;
    end else if (push_c && redirect_c) begin
      bus.br_en   = 1'b1;
      bus.br_addr = tgt_c;
    end
  end

  // Decode-side view of the head entry.
  assign bus.d_valid      = (count != '0);
  assign bus.d_pc         = mem[rd_ptr].pc;
  assign bus.d_instr      = mem[rd_ptr].instr;
  assign bus.d_pred_taken = mem[rd_ptr].pred;

  // Queue storage, pointers and occupancy; flush on execute redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.ex_br_en) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= wr_entry_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
